// File: rtl/operand_issue.sv
// operand_issue: resolves operands (PC, priority bypass, regfile), stalls on scoreboard/RAW/WAW hazards, holds them in a valid/ready issue register with flush
module operand_issue #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int NUM_RD    = 3,
  parameter int NUM_BYP   = 2,
  parameter int PC_OFFSET = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_insn,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [NUM_RD*REG_AW-1:0]   in_rsel,
  input  logic [NUM_RD-1:0]          in_ruse,
  input  logic [REG_AW-1:0]          in_wsel,
  input  logic                       in_wuse,
  input  logic                       in_wlate,
  output logic [NUM_RD*REG_AW-1:0]   rf_raddr,
  input  logic [NUM_RD*DATA_W-1:0]   rf_rdata,
  input  logic [NUM_BYP-1:0]         byp_valid,
  input  logic [NUM_BYP*REG_AW-1:0]  byp_addr,
  input  logic [NUM_BYP*DATA_W-1:0]  byp_data,
  input  logic                       ret_valid,
  input  logic [REG_AW-1:0]          ret_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [DATA_W-1:0]          out_pc,
  output logic [NUM_RD*DATA_W-1:0]   out_op,
  output logic [REG_AW-1:0]          out_wsel,
  output logic                       out_wuse,
  output logic                       out_wlate
);
  localparam logic [REG_AW-1:0] PC_IDX = '1;
  logic                      valid_q, valid_d;
  logic [31:0]               insn_q, insn_d;
  logic [DATA_W-1:0]         pc_q, pc_d;
  logic [NUM_RD*DATA_W-1:0]  op_q, op_d, op_res;
  logic [REG_AW-1:0]         wsel_q, wsel_d;
  logic                      wuse_q, wuse_d;
  logic                      wlate_q, wlate_d;
  logic [2**REG_AW-1:0]      sb_q, sb_d;
  logic [REG_AW-1:0]         r;
  logic                      hazard, accept;
  always_comb begin
    r = '0;
    op_res = '0;
    hazard = in_wuse && in_wlate && sb_q[in_wsel] && !(ret_valid && ret_addr == in_wsel);
    for (int k = 0; k < NUM_RD; k++) begin
      r = in_rsel[k*REG_AW +: REG_AW];
      op_res[k*DATA_W +: DATA_W] = rf_rdata[k*DATA_W +: DATA_W];
      for (int j = NUM_BYP - 1; j >= 0; j--)
        op_res[k*DATA_W +: DATA_W] = (byp_valid[j] && byp_addr[j*REG_AW +: REG_AW] == r) ?
                                     byp_data[j*DATA_W +: DATA_W] : op_res[k*DATA_W +: DATA_W];
      op_res[k*DATA_W +: DATA_W] = (r == PC_IDX) ? in_pc - DATA_W'(PC_OFFSET) : op_res[k*DATA_W +: DATA_W];
      hazard = hazard || (in_ruse[k] && r != PC_IDX &&
               ((sb_q[r] && !(ret_valid && ret_addr == r)) || (valid_q && wuse_q && wsel_q == r)));
    end
  end
  assign rf_raddr = in_rsel;
  assign in_ready = !rst && !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  always_comb begin
    valid_d = accept || (valid_q && !out_ready && !flush);
    insn_d  = accept ? in_insn  : insn_q;
    pc_d    = accept ? in_pc    : pc_q;
    op_d    = accept ? op_res   : op_q;
    wsel_d  = accept ? in_wsel  : wsel_q;
    wuse_d  = accept ? in_wuse  : wuse_q;
    wlate_d = accept ? in_wlate : wlate_q;
    sb_d    = sb_q;
    if (ret_valid) sb_d[ret_addr] = 1'b0;
    if (valid_q && out_ready && wuse_q && wlate_q && wsel_q != PC_IDX) sb_d[wsel_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      insn_q  <= '0;
      pc_q    <= '0;
      op_q    <= '0;
      wsel_q  <= '0;
      wuse_q  <= 1'b0;
      wlate_q <= 1'b0;
      sb_q    <= '0;
    end else begin
      valid_q <= valid_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      wsel_q  <= wsel_d;
      wuse_q  <= wuse_d;
      wlate_q <= wlate_d;
      sb_q    <= sb_d;
    end
  end
  assign out_valid = valid_q;
  assign out_insn  = insn_q;
  assign out_pc    = pc_q;
  assign out_op    = op_q;
  assign out_wsel  = wsel_q;
  assign out_wuse  = wuse_q;
  assign out_wlate = wlate_q;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed self-checking bench for operand_issue
module tb_operand_issue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_insn, in_pc;
  logic [11:0] in_rsel;
  logic [2:0]  in_ruse;
  logic [3:0]  in_wsel;
  logic        in_wuse, in_wlate;
  logic [11:0] rf_raddr;
  logic [95:0] rf_rdata;
  logic [1:0]  byp_valid;
  logic [7:0]  byp_addr;
  logic [63:0] byp_data;
  logic        ret_valid;
  logic [3:0]  ret_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_insn, out_pc;
  logic [95:0] out_op;
  logic [3:0]  out_wsel;
  logic        out_wuse, out_wlate;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  operand_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .in_rsel(in_rsel), .in_ruse(in_ruse),
    .in_wsel(in_wsel), .in_wuse(in_wuse), .in_wlate(in_wlate),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .ret_valid(ret_valid), .ret_addr(ret_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
    .out_op(out_op), .out_wsel(out_wsel), .out_wuse(out_wuse), .out_wlate(out_wlate)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic insn(input logic [31:0] i, input logic [2:0] ruse, input logic [11:0] rsel,
                      input logic [3:0] wsel, input logic wuse, input logic wlate);
    in_valid = 1'b1;
    in_insn  = i;
    in_ruse  = ruse;
    in_rsel  = rsel;
    in_wsel  = wsel;
    in_wuse  = wuse;
    in_wlate = wlate;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = 32'h100;
    in_rsel = '0; in_ruse = '0; in_wsel = '0; in_wuse = 1'b0; in_wlate = 1'b0;
    rf_rdata = '0; byp_valid = '0; byp_addr = '0; byp_data = '0;
    ret_valid = 1'b0; ret_addr = '0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_out_op0", out_op[31:0], 32'd0);
    chk("rst_sb", {16'd0, dut.sb_q}, 32'd0);
    rst = 1'b0;
    // forwarding priority
    insn(32'h1, 3'b001, {4'd0, 4'd0, 4'd3}, 4'd0, 1'b0, 1'b0);
    rf_rdata = {32'h0, 32'h0, 32'h11};
    byp_valid = 2'b11; byp_addr = {4'd3, 4'd3}; byp_data = {32'hBB, 32'hAA};
    settle();
    chk("fwd_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("fwd_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_byp0", out_op[31:0], 32'hAA);
    chk("fwd_pc", out_pc, 32'h100);
    byp_valid = 2'b10;
    cyc();
    chk("fwd_byp1", out_op[31:0], 32'hBB);
    byp_valid = 2'b00;
    cyc();
    chk("fwd_rf", out_op[31:0], 32'h11);
    // PC read beats bypass on the all-ones index
    insn(32'h2, 3'b010, {4'd0, 4'hF, 4'd0}, 4'd0, 1'b0, 1'b0);
    in_pc = 32'h1000; byp_valid = 2'b01; byp_addr = {4'd0, 4'hF}; byp_data = {32'h0, 32'hDEAD};
    cyc();
    chk("pc_1000", out_op[63:32], 32'h0FF8);
    in_pc = 32'h4; byp_valid = 2'b00;
    cyc();
    chk("pc_wrap", out_op[63:32], 32'hFFFFFFFC);
    // late load then use
    insn(32'h50, 3'b000, 12'd0, 4'd5, 1'b1, 1'b1);
    cyc();
    chk("ld5_wsel", {28'd0, out_wsel}, 32'd5);
    insn(32'h51, 3'b001, {4'd0, 4'd0, 4'd5}, 4'd0, 1'b0, 1'b0);
    settle();
    chk("ld5_occ_stall", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("ld5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ld5_sb_set", {16'd0, dut.sb_q}, 32'h20);
    chk("ld5_sb_stall", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("ld5_sb_stall2", {31'd0, in_ready}, 32'd0);
    ret_valid = 1'b1; ret_addr = 4'd5;
    byp_valid = 2'b01; byp_addr = {4'd0, 4'd5}; byp_data = {32'h0, 32'h77};
    settle();
    chk("ld5_ret_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("ld5_op", out_op[31:0], 32'h77);
    chk("ld5_insn", out_insn, 32'h51);
    chk("ld5_sb_clr", {16'd0, dut.sb_q}, 32'd0);
    ret_valid = 1'b0; byp_valid = 2'b00;
    // occupant RAW
    insn(32'h20, 3'b000, 12'd0, 4'd2, 1'b1, 1'b0);
    cyc();
    chk("add_wsel", {28'd0, out_wsel}, 32'd2);
    out_ready = 1'b0;
    insn(32'h44, 3'b001, {4'd0, 4'd0, 4'd2}, 4'd0, 1'b0, 1'b0);
    settle();
    chk("raw_stall", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("raw_hold", out_insn, 32'h20);
    out_ready = 1'b1; byp_valid = 2'b01; byp_addr = {4'd0, 4'd2}; byp_data = {32'h0, 32'h9};
    settle();
    chk("raw_bubble", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("raw_drain", {31'd0, out_valid}, 32'd0);
    chk("raw_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("raw_op", out_op[31:0], 32'h9);
    chk("raw_insn", out_insn, 32'h44);
    byp_valid = 2'b00;
    // backpressure then flush without handoff
    insn(32'h88, 3'b000, 12'd0, 4'd8, 1'b1, 1'b1);
    cyc();
    out_ready = 1'b0;
    insn(32'h66, 3'b000, 12'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("bp_insn", out_insn, 32'h88);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    flush = 1'b1;
    settle();
    chk("fl_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_sb", {16'd0, dut.sb_q}, 32'd0);
    // flush with handoff still sets the scoreboard
    flush = 1'b0; out_ready = 1'b1;
    insn(32'h60, 3'b000, 12'd0, 4'd6, 1'b1, 1'b1);
    cyc();
    insn(32'h66, 3'b000, 12'd0, 4'd0, 1'b0, 1'b0);
    flush = 1'b1;
    settle();
    chk("flh_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("flh_valid", {31'd0, out_valid}, 32'd0);
    chk("flh_sb", {16'd0, dut.sb_q}, 32'h40);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("flh_sb_keep", {16'd0, dut.sb_q}, 32'h40);
    ret_valid = 1'b1; ret_addr = 4'd6;
    cyc();
    chk("flh_sb_ret", {16'd0, dut.sb_q}, 32'd0);
    ret_valid = 1'b0;
    // WAW and set/clear collision
    insn(32'h70, 3'b000, 12'd0, 4'd7, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("c7_sb", {16'd0, dut.sb_q}, 32'h80);
    insn(32'h71, 3'b000, 12'd0, 4'd7, 1'b1, 1'b1);
    settle();
    chk("waw_stall", {31'd0, in_ready}, 32'd0);
    ret_valid = 1'b1; ret_addr = 4'd7;
    settle();
    chk("waw_ret_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("waw_insn", out_insn, 32'h71);
    chk("waw_sb_clr", {16'd0, dut.sb_q}, 32'd0);
    in_valid = 1'b0;
    cyc();
    chk("coll_sb", {16'd0, dut.sb_q}, 32'h80);
    ret_valid = 1'b0;
    // reset mid-stall
    out_ready = 1'b0;
    insn(32'h99, 3'b000, 12'd0, 4'd0, 1'b0, 1'b0);
    cyc();
    chk("ms_valid", {31'd0, out_valid}, 32'd1);
    insn(32'h9A, 3'b001, {4'd0, 4'd0, 4'd7}, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    settle();
    chk("ms_stall", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    cyc();
    chk("ms_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("ms_rst_sb", {16'd0, dut.sb_q}, 32'd0);
    chk("ms_rst_insn", out_insn, 32'd0);
    chk("ms_rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    settle();
    chk("ms_after_ready", {31'd0, in_ready}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Parametrised operand-fetch and issue stage that sits between instruction decode and execute.
- Generalises the fixed three-read-port decode register stage by adding N read ports, M priority bypass channels, and a late-result scoreboard that stalls on hazards.
- Adds a valid/ready pipeline register with flush.
- The upstream decoder supplies register indices; this block reads the register file, resolves forwarding and r15, detects hazards, and holds the issued operands.

Parameters:
DATA_W, 32, datapath width
REG_AW, 4, register index width (2^REG_AW architectural registers)
NUM_RD, 3, read ports / operand slots
NUM_BYP, 2, bypass channels; channel 0 = youngest, highest priority
PC_OFFSET, 8, subtracted from in_pc when the all-ones register (PC) is read

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard in-stage instruction and refuse input this cycle
in_valid  in  1  decoded instruction offered
in_ready  out  1  instruction accepted when in_valid&in_ready
in_insn  in  32  raw instruction
in_pc  in  DATA_W  fetch PC
in_rsel  in  NUM_RD*REG_AW  read index per slot (slot k = bits k*REG_AW+:REG_AW)
in_ruse  in  NUM_RD  slot k is a real source
in_wsel  in  REG_AW  destination register
in_wuse  in  1  instruction writes in_wsel
in_wlate  in  1  result is late (load); tracked in scoreboard
rf_raddr  out  NUM_RD*REG_AW  register-file read addresses (= in_rsel, combinational)
rf_rdata  in  NUM_RD*DATA_W  register-file data, same cycle
byp_valid  in  NUM_BYP  bypass channel carries a result
byp_addr  in  NUM_BYP*REG_AW  bypass destination
byp_data  in  NUM_BYP*DATA_W  bypass value
ret_valid  in  1  late result retired to register file
ret_addr  in  REG_AW  retired register
out_valid  out  1  issue register holds an instruction
out_ready  in  1  execute accepts
out_insn  out  32  issued instruction
out_pc  out  DATA_W  issued PC
out_op  out  NUM_RD*DATA_W  resolved operands
out_wsel  out  REG_AW  issued destination
out_wuse  out  1  issued writes
out_wlate  out  1  issued late

Behaviour:
- Reset: out_valid=0, all scoreboard bits=0, and out_insn/out_pc/out_op/out_wsel/out_wuse/out_wlate=0. in_ready is 0 during rst.
- Operand resolution, per slot k, combinational, first match wins:
  1. rsel == all-ones gives in_pc - PC_OFFSET, modulo 2^DATA_W.
  2. Otherwise, the lowest-numbered channel j with byp_valid[j] && byp_addr[j]==rsel gives byp_data[j].
  3. Otherwise, rf_rdata[k].
  - Unused slots (ruse=0) still capture their resolved value; verification must not check them.
- Hazard (slot k is used, rsel != all-ones) is true when any of these holds:
  - sb[rsel]=1 and there is no ret_valid with ret_addr==rsel this cycle. A retired value counts as a bypass hit only through the byp channels, so the integrator drives ret onto a byp channel.
  - out_valid && out_wuse && out_wsel==rsel (RAW on the occupant; costs one bubble).
- WAW hazard: in_wuse && in_wlate && sb[in_wsel]=1 with no same-cycle retire of that register.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Issue register:
  - Loads on in_valid&&in_ready; latency is 1 cycle from accept to out_valid.
  - Holds all out_* stable while out_valid && !out_ready.
  - If out_ready and nothing is accepted, clears out_valid.
- Scoreboard:
  - Sets sb[out_wsel] when out_valid&&out_ready&&out_wuse&&out_wlate.
  - Clears sb[ret_addr] on ret_valid.
  - When set and clear hit the same register in the same cycle, set wins.
  - sb[all-ones] is never set.
- flush:
  - Clears out_valid next cycle; in_ready=0 that cycle.
  - Scoreboard is untouched: instructions already past issue still retire.
  - If the occupant is handed off (out_ready=1) in the flush cycle, its scoreboard set still occurs.
- Integration requirement: the bypass channels cover every in-flight non-late result between issue output and register-file write.
- rst mid-stall discards the occupant and all pending scoreboard state.

Test Plan:
1. Forwarding priority: rf_rdata slot0=0x11, byp0={r3,0xAA}, byp1={r3,0xBB}, in_rsel0=r3 -> out_op slot0=0xAA next cycle; with only byp1 valid -> 0xBB.
2. PC read: in_rsel1=4'hF, in_pc=0x1000 -> out_op slot1=0x0FF8; with in_pc=0x4 -> 0xFFFFFFFC.
3. Late load then use: issue load r5 (wlate), next instruction reads r5 -> in_ready=0 until ret_valid r5 with byp0={r5,0x77}; that cycle in_ready=1 and the operand is 0x77; sb[5]=0 afterwards.
4. Occupant RAW: out reg holds ADD r2 with out_ready=0, incoming reads r2 -> stalls; after out_ready=1 and byp0 carries r2=0x9 -> accepted, operand 0x9.
5. Backpressure/flush: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; flush asserted -> out_valid=0 next cycle, sb unchanged.
6. Set/clear collision: retire r7 in the same cycle a late write to r7 issues -> sb[7]=1. Reset mid-stall -> out_valid=0 and sb all 0 the following cycle.
